// File: rtl/pc_sequencer.sv
// Architectural PC owner: fixed-priority next-PC select, fetch handshake, halt/resume, misaligned-target fault.
// Optional return-address stack enabled by defining PC_SEQUENCER_RAS_EN.
module pc_sequencer #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
   parameter logic [XLEN-1:0] FAULT_VECTOR = XLEN'(32'h0000_0100),
   parameter int              ALIGN_BITS   = 2,
   parameter int              RAS_DEPTH    = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic [XLEN-1:0] pc,
   output logic            pc_valid,
   input  logic            fetch_ready,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   input  logic            jump_valid,
   input  logic [XLEN-1:0] jump_target,
   input  logic            jump_use_ras,
   input  logic            ras_push,
   input  logic [XLEN-1:0] ras_push_addr,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_vector,
   input  logic            halt_req,
   input  logic            resume_req,
   output logic            halted,
   output logic            misalign_fault,
   output logic [XLEN-1:0] fault_addr
);

   typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

   state_t          state;
   logic            sel_valid;
   logic [XLEN-1:0] sel_target;
   logic            redirect;
   logic            misaligned;

`ifdef PC_SEQUENCER_RAS_EN
   localparam int PW = $clog2(RAS_DEPTH);

   logic [XLEN-1:0] ras_mem [RAS_DEPTH];
   logic [PW-1:0]   ras_ptr;
   logic [PW-1:0]   ras_top_idx;
   logic [XLEN-1:0] ras_top;
   logic            ras_pop;

   assign ras_top_idx = ras_ptr - PW'(1);
   assign ras_top     = ras_mem[ras_top_idx];
   // A return only consumes the stack when the jump actually wins arbitration and is applied.
   assign ras_pop     = redirect && !trap_valid && jump_valid && jump_use_ras;
`else
   localparam int unused_ras_depth = RAS_DEPTH;
   logic          unused_ras_inputs;
   assign unused_ras_inputs = ^{jump_use_ras, ras_push, ras_push_addr};
`endif

   always_comb begin
      sel_valid  = 1'b0;
      sel_target = '0;
      if (trap_valid) begin
         sel_valid  = 1'b1;
         sel_target = trap_vector;
      end else if (jump_valid) begin
         sel_valid  = 1'b1;
`ifdef PC_SEQUENCER_RAS_EN
         sel_target = jump_use_ras ? ras_top : jump_target;
`else
         sel_target = jump_target;
`endif
      end else if (branch_taken) begin
         sel_valid  = 1'b1;
         sel_target = branch_target;
      end
   end

   assign redirect   = sel_valid && ((state == S_RUN) || (state == S_HALT));
   assign misaligned = |sel_target[ALIGN_BITS-1:0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= S_BOOT;
         pc             <= RESET_VECTOR;
         pc_valid       <= 1'b0;
         halted         <= 1'b0;
         misalign_fault <= 1'b0;
         fault_addr     <= '0;
      end else begin
         misalign_fault <= 1'b0;
         if (redirect) begin
            if (misaligned) begin
               pc             <= FAULT_VECTOR;
               misalign_fault <= 1'b1;
               fault_addr     <= sel_target;
            end else begin
               pc <= sel_target;
            end
         end else if ((state == S_RUN) && pc_valid && fetch_ready) begin
            pc <= pc + XLEN'(4);
         end

         case (state)
            S_BOOT: begin
               state    <= S_RUN;
               pc_valid <= 1'b1;
               halted   <= 1'b0;
            end
            S_RUN: begin
               if (halt_req) begin
                  state    <= S_HALT;
                  pc_valid <= 1'b0;
                  halted   <= 1'b1;
               end
            end
            S_HALT: begin
               if (resume_req) begin
                  state    <= S_RUN;
                  pc_valid <= 1'b1;
                  halted   <= 1'b0;
               end
            end
            default: begin
               state    <= S_BOOT;
               pc_valid <= 1'b0;
               halted   <= 1'b0;
            end
         endcase
      end
   end

`ifdef PC_SEQUENCER_RAS_EN
   // Push+pop together swaps the top entry in place, so the pointer stays put.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ras_ptr <= '0;
         ras_mem <= '{default: '0};
      end else if (ras_pop && ras_push) begin
         ras_mem[ras_top_idx] <= ras_push_addr;
      end else if (ras_pop) begin
         ras_ptr <= ras_top_idx;
      end else if (ras_push) begin
         ras_mem[ras_ptr] <= ras_push_addr;
         ras_ptr          <= ras_ptr + PW'(1);
      end
   end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a cycle-level reference model; covers the RAS when PC_SEQUENCER_RAS_EN is defined.
module tb_pc_sequencer;

   localparam int          RAS_D   = 4;
   localparam logic [31:0] RST_VEC = 32'h0000_0000;
   localparam logic [31:0] FLT_VEC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc;
   logic        pc_valid;
   logic        fetch_ready;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump_valid;
   logic [31:0] jump_target;
   logic        jump_use_ras;
   logic        ras_push;
   logic [31:0] ras_push_addr;
   logic        trap_valid;
   logic [31:0] trap_vector;
   logic        halt_req;
   logic        resume_req;
   logic        halted;
   logic        misalign_fault;
   logic [31:0] fault_addr;

   int tests = 0;
   int fails = 0;

   pc_sequencer dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pc             (pc),
      .pc_valid       (pc_valid),
      .fetch_ready    (fetch_ready),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .jump_valid     (jump_valid),
      .jump_target    (jump_target),
      .jump_use_ras   (jump_use_ras),
      .ras_push       (ras_push),
      .ras_push_addr  (ras_push_addr),
      .trap_valid     (trap_valid),
      .trap_vector    (trap_vector),
      .halt_req       (halt_req),
      .resume_req     (resume_req),
      .halted         (halted),
      .misalign_fault (misalign_fault),
      .fault_addr     (fault_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: mode 0 = booting, 1 = running, 2 = halted.
   logic [31:0] m_pc, m_faddr;
   int          m_mode;
   bit          m_fault;
   bit          m_known = 1'b0;
   logic [31:0] m_ras [RAS_D];
   int          m_sp;

   always @(posedge clk) begin
      logic [31:0] tgt;
      bit          redir;
      bit          pop;
      if (!rst_n) begin
         m_pc    = RST_VEC;
         m_mode  = 0;
         m_fault = 1'b0;
         m_faddr = 32'h0;
         m_sp    = 0;
         for (int i = 0; i < RAS_D; i++) m_ras[i] = 32'h0;
         m_known = 1'b1;
      end else if (m_known) begin
         redir   = 1'b0;
         pop     = 1'b0;
         tgt     = 32'h0;
         m_fault = 1'b0;
         if (m_mode != 0) begin
            if (trap_valid) begin
               redir = 1'b1;
               tgt   = trap_vector;
            end else if (jump_valid) begin
               redir = 1'b1;
               tgt   = jump_target;
`ifdef PC_SEQUENCER_RAS_EN
               if (jump_use_ras) begin
                  tgt = m_ras[(m_sp + RAS_D - 1) % RAS_D];
                  pop = 1'b1;
               end
`endif
            end else if (branch_taken) begin
               redir = 1'b1;
               tgt   = branch_target;
            end
         end
`ifdef PC_SEQUENCER_RAS_EN
         if (pop && ras_push) m_ras[(m_sp + RAS_D - 1) % RAS_D] = ras_push_addr;
         else if (pop) m_sp = (m_sp + RAS_D - 1) % RAS_D;
         else if (ras_push) begin
            m_ras[m_sp] = ras_push_addr;
            m_sp        = (m_sp + 1) % RAS_D;
         end
`endif
         if (redir) begin
            if ((tgt % 4) != 0) begin
               m_pc    = FLT_VEC;
               m_fault = 1'b1;
               m_faddr = tgt;
            end else begin
               m_pc = tgt;
            end
         end else if (m_mode == 1 && fetch_ready) begin
            m_pc = m_pc + 32'd4;
         end
         if (m_mode == 0) m_mode = 1;
         else if (m_mode == 1 && halt_req) m_mode = 2;
         else if (m_mode == 2 && resume_req) m_mode = 1;
      end
      #2;
      if (m_known) begin
         chk("model_pc", pc, m_pc);
         chk("model_pc_valid", {31'h0, pc_valid}, {31'h0, m_mode == 1});
         chk("model_halted", {31'h0, halted}, {31'h0, m_mode == 2});
         chk("model_fault", {31'h0, misalign_fault}, {31'h0, m_fault});
         chk("model_fault_addr", fault_addr, m_faddr);
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic clear_req();
      branch_taken = 1'b0; jump_valid = 1'b0; jump_use_ras = 1'b0;
      ras_push = 1'b0; trap_valid = 1'b0; halt_req = 1'b0; resume_req = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; fetch_ready = 1'b0;
      branch_target = 32'h0; jump_target = 32'h0; ras_push_addr = 32'h0; trap_vector = 32'h0;
      clear_req();
      step(); step();
      chk("rst_pc", pc, 32'h0);
      chk("rst_pc_valid", {31'h0, pc_valid}, 32'h0);
      chk("rst_halted", {31'h0, halted}, 32'h0);
      chk("rst_fault", {31'h0, misalign_fault}, 32'h0);
      chk("rst_fault_addr", fault_addr, 32'h0);

      // Boot: one cycle without pc_valid, then sequential fetch.
      rst_n = 1'b1; fetch_ready = 1'b1;
      step(); chk("boot_valid", {31'h0, pc_valid}, 32'h1); chk("seq0", pc, 32'h0);
      step(); chk("seq4", pc, 32'h4);
      step(); chk("seq8", pc, 32'h8);
      fetch_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(); chk("stall_pc", pc, 32'h8); chk("stall_valid", {31'h0, pc_valid}, 32'h1);
      end
      fetch_ready = 1'b1;
      step(); chk("resume_fetch", pc, 32'hC);

      // Priority: trap beats jump beats branch.
      trap_valid = 1'b1; trap_vector = 32'h200;
      jump_valid = 1'b1; jump_target = 32'h40;
      branch_taken = 1'b1; branch_target = 32'h80;
      step(); chk("prio_pc", pc, 32'h200); chk("prio_nofault", {31'h0, misalign_fault}, 32'h0);
      clear_req(); fetch_ready = 1'b0;

      branch_taken = 1'b1; branch_target = 32'h102;
      step(); chk("mis_pc", pc, 32'h100); chk("mis_pulse", {31'h0, misalign_fault}, 32'h1);
      chk("mis_addr", fault_addr, 32'h102);
      clear_req();
      step(); chk("mis_pulse_end", {31'h0, misalign_fault}, 32'h0); chk("mis_addr_held", fault_addr, 32'h102);

      // Halt, redirect while halted, resume.
      jump_valid = 1'b1; jump_target = 32'h20;
      step(); clear_req();
      halt_req = 1'b1;
      step(); chk("halt_h", {31'h0, halted}, 32'h1); chk("halt_v", {31'h0, pc_valid}, 32'h0);
      chk("halt_pc", pc, 32'h20);
      halt_req = 1'b0; jump_valid = 1'b1; jump_target = 32'h60;
      step(); chk("halt_jump", pc, 32'h60); chk("halt_stays", {31'h0, halted}, 32'h1);
      clear_req(); resume_req = 1'b1;
      step(); chk("resume_v", {31'h0, pc_valid}, 32'h1); chk("resume_pc", pc, 32'h60);
      clear_req();

      // Halt with a completing handshake still advances; simultaneous halt/resume.
      halt_req = 1'b1; fetch_ready = 1'b1;
      step(); chk("halt_adv_pc", pc, 32'h64); chk("halt_adv_h", {31'h0, halted}, 32'h1);
      resume_req = 1'b1;
      step(); chk("both_in_halt", {31'h0, halted}, 32'h0); chk("both_in_halt_pc", pc, 32'h64);
      step(); chk("both_in_run", {31'h0, halted}, 32'h1); chk("both_in_run_pc", pc, 32'h68);
      halt_req = 1'b0;
      step(); chk("resume2", {31'h0, halted}, 32'h0);
      clear_req(); fetch_ready = 1'b0;

      trap_valid = 1'b1; trap_vector = 32'h202;
      step(); chk("trap_mis_pc", pc, 32'h100); chk("trap_mis_addr", fault_addr, 32'h202);
      clear_req();

      jump_valid = 1'b1; jump_target = 32'hFFFF_FFFC;
      step(); chk("wrap_top", pc, 32'hFFFF_FFFC);
      clear_req(); fetch_ready = 1'b1;
      step(); chk("wrap_zero", pc, 32'h0);
      fetch_ready = 1'b0;

`ifdef PC_SEQUENCER_RAS_EN
      ras_push = 1'b1; ras_push_addr = 32'h1000; step();
      ras_push_addr = 32'h2000; step();
      ras_push = 1'b0; jump_valid = 1'b1; jump_use_ras = 1'b1; jump_target = 32'h500;
      step(); chk("ras_ret1", pc, 32'h2000);
      step(); chk("ras_ret2", pc, 32'h1000);
      clear_req();
      ras_push = 1'b1; ras_push_addr = 32'h3000; step();
      ras_push_addr = 32'h4000; jump_valid = 1'b1; jump_use_ras = 1'b1;
      step(); chk("ras_swap", pc, 32'h3000);
      ras_push = 1'b0;
      step(); chk("ras_after_swap", pc, 32'h4000);
      step(); chk("ras_empty_pop", pc, 32'h0);
      clear_req();
      ras_push = 1'b1; ras_push_addr = 32'h1002; step();
      ras_push = 1'b0; jump_valid = 1'b1; jump_use_ras = 1'b1;
      step(); chk("ras_mis_pc", pc, 32'h100); chk("ras_mis_addr", fault_addr, 32'h1002);
      clear_req();
`else
      jump_valid = 1'b1; jump_use_ras = 1'b1; jump_target = 32'h700;
      ras_push = 1'b1; ras_push_addr = 32'h900;
      step(); chk("noras_jump1", pc, 32'h700);
      jump_target = 32'h740;
      step(); chk("noras_jump2", pc, 32'h740);
      clear_req();
`endif

      // Reset overrides pending halt and trap.
      halt_req = 1'b1; trap_valid = 1'b1; trap_vector = 32'h300; rst_n = 1'b0;
      step(); chk("mid_rst_pc", pc, 32'h0); chk("mid_rst_v", {31'h0, pc_valid}, 32'h0);
      chk("mid_rst_h", {31'h0, halted}, 32'h0); chk("mid_rst_faddr", fault_addr, 32'h0);
      clear_req(); rst_n = 1'b1; fetch_ready = 1'b1;
      step(); chk("reboot_v", {31'h0, pc_valid}, 32'h1); chk("reboot_pc", pc, 32'h0);
      step(); chk("reboot_seq", pc, 32'h4);
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised successor to the combinational next-PC select: owns the architectural PC register, picks the next PC from sequential, branch, jump and trap sources by fixed priority, and offers the PC to fetch over a valid/ready handshake.
- Adds halt/resume control, misaligned-target fault detection and an optional return-address stack.
- Sits between the execute-stage redirect sources and the instruction-fetch stage.

Parameters:
- XLEN, 32, PC and target width in bits (>= 8).
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- FAULT_VECTOR, 32'h0000_0100, PC loaded when a misaligned target is detected.
- ALIGN_BITS, 2, low target bits that must be zero (2 = 4-byte, 1 = 2-byte).
- RAS_DEPTH, 4, return-address stack entries (power of two, >= 2); used only with the optional feature.

Ports:
- clk in 1 rising-edge clock.
- rst_n in 1 reset; synchronous, active-low.
- pc out XLEN current fetch PC.
- pc_valid out 1 pc is offered to fetch.
- fetch_ready in 1 fetch accepts pc this cycle.
- branch_taken in 1 conditional branch resolved taken.
- branch_target in XLEN branch destination.
- jump_valid in 1 JAL/JALR redirect.
- jump_target in XLEN jump destination.
- jump_use_ras in 1 jump is a return; take target from RAS (feature only).
- ras_push in 1 push ras_push_addr (call).
- ras_push_addr in XLEN return address to push.
- trap_valid in 1 trap/exception redirect.
- trap_vector in XLEN trap handler address.
- halt_req in 1 request halt.
- resume_req in 1 request resume.
- halted out 1 sequencer in HALT.
- misalign_fault out 1 one-cycle pulse: redirect target misaligned.
- fault_addr out XLEN offending target, held until next fault.

Behaviour:
- Reset (rst_n=0 at a clk edge): pc=RESET_VECTOR, pc_valid=0, halted=0, misalign_fault=0, fault_addr=0, state=BOOT, RAS pointer=0, RAS entries=0.
- States:
  - BOOT: pc_valid=0; always -> RUN next cycle, so pc_valid first rises in the 2nd cycle after rst_n goes high.
  - RUN: pc_valid=1.
  - HALT: pc_valid=0, halted=1.
- Redirect select:
  - Priority is trap_valid > jump_valid > branch_taken.
  - A redirect is taken at the next edge in RUN or HALT regardless of fetch_ready, flushing the offered pc.
  - Lower-priority simultaneous requests are dropped.
- Alignment check:
  - If the selected redirect target has any of bits [ALIGN_BITS-1:0] nonzero, pc<=FAULT_VECTOR instead of the target.
  - misalign_fault pulses high for 1 cycle; fault_addr<=target.
  - trap_vector is checked too; a misaligned trap_vector also goes to FAULT_VECTOR.
- Sequential advance: with no redirect, in RUN with pc_valid && fetch_ready, pc<=pc+4 modulo 2^XLEN (0xFFFF_FFFC wraps to 0x0). Otherwise pc holds.
- Halt:
  - halt_req in RUN -> HALT at the next edge; pc holds.
  - If a fetch handshake completes on the same cycle, pc still advances by 4 before halting.
  - resume_req in HALT -> RUN next edge.
  - halt_req and resume_req together: halt_req wins in RUN, resume_req wins in HALT.
  - Redirects are still applied in HALT (pc updated, stays halted).
- Reset mid-operation overrides everything at that edge, including pending halt and redirects.
- Output latency: pc, pc_valid, halted and misalign_fault are registered outputs; no combinational input-to-output path.

Optional Feature:
- PC_SEQUENCER_RAS_EN defined:
  - Circular RAS of RAS_DEPTH entries.
  - ras_push writes ras_push_addr at ptr and increments ptr; overflow overwrites the oldest entry.
  - A jump with jump_use_ras uses the top entry (ptr-1) as the target and decrements ptr.
  - Pop on an empty stack returns the last value at that slot; the pointer wraps.
  - Push and pop in the same cycle: the target is the old top, and the top entry is replaced by ras_push_addr; ptr is unchanged.
  - The RAS target goes through the alignment check.
- PC_SEQUENCER_RAS_EN undefined: no RAS storage; jump_use_ras, ras_push and ras_push_addr are ignored; a jump always uses jump_target.

Test Plan:
- Reset, then rst_n=1 with fetch_ready=1: pc_valid=0 for 1 cycle, then pc=0x0, 0x4, 0x8 on successive cycles.
- fetch_ready=0 for 3 cycles at pc=0x8: pc stays 0x8, pc_valid stays 1; ready rises -> 0xC.
- trap_valid (vector 0x200), jump_valid (0x40) and branch_taken (0x80) in one cycle: next pc=0x200, no fault.
- branch_taken, target 0x102: pc=0x100 (FAULT_VECTOR), misalign_fault pulses 1 cycle, fault_addr=0x102.
- halt_req at pc=0x20 with fetch_ready=0: halted=1, pc_valid=0, pc=0x20; jump to 0x60 while halted -> pc=0x60; resume_req -> pc_valid=1, pc=0x60.
- PC_SEQUENCER_RAS_EN defined:
  - Push 0x1000, then push 0x2000, then a jump with jump_use_ras: pc=0x2000.
  - A second return: pc=0x1000.
  - Pc forced to 0xFFFF_FFFC via jump, then advance: pc=0x0.
